// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// the counter-width helper used to size the hold/gap down-counter.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Bits needed to hold any value 0..max(a,b).
    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Trigger-to-fixed-width pulse stretcher with enforced low gap and a one-deep
// request queue. Define PULSE_STRETCH_RETRIGGER_EN to let triggers during HOLD extend the pulse.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HOLD_CYCLES = 10000,
    parameter int GAP_CYCLES  = 1000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_trigger,
    output logic o_pulse,
    output logic o_busy,
    output logic o_pending
);

    localparam int CNT_W = clog2_max(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : CNT_ZERO;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

`ifdef PULSE_STRETCH_RETRIGGER_EN
    localparam bit RETRIGGER = 1'b1;
`else
    localparam bit RETRIGGER = 1'b0;
`endif

    // Power-up values match the reset values so FPGA configuration starts idle.
    state_e           state_q   = IDLE;
    logic [CNT_W-1:0] cnt_q     = {CNT_W{1'b0}};
    logic             pending_q = 1'b0;
    logic             pulse_q   = 1'b0;
    logic             busy_q    = 1'b0;

    state_e           state_d;
    logic [CNT_W-1:0] cnt_d;
    logic             pending_d;
    logic             pulse_d;
    logic             busy_d;
    logic             cnt_last_s;
    logic             req_s;

    assign cnt_last_s = (cnt_q == CNT_ZERO);
    assign req_s      = pending_q | i_trigger;

    // Next-state, counter and queued-request logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;

        case (state_q)
            IDLE: begin
                if (i_trigger) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end

            HOLD: begin
                if (RETRIGGER && i_trigger) begin
                    cnt_d = HOLD_LOAD;
                end else if (!cnt_last_s) begin
                    cnt_d     = cnt_q - CNT_ONE;
                    pending_d = req_s;
                end else if (HAS_GAP) begin
                    state_d   = GAP;
                    cnt_d     = GAP_LOAD;
                    pending_d = req_s;
                end else if (req_s) begin
                    // No gap configured: back-to-back pulse merges into one high level.
                    cnt_d     = HOLD_LOAD;
                    pending_d = 1'b0;
                end else begin
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    pending_d = 1'b0;
                end
            end

            GAP: begin
                if (!cnt_last_s) begin
                    cnt_d     = cnt_q - CNT_ONE;
                    pending_d = req_s;
                end else if (req_s) begin
                    state_d   = HOLD;
                    cnt_d     = HOLD_LOAD;
                    pending_d = 1'b0;
                end else begin
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    pending_d = 1'b0;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = CNT_ZERO;
                pending_d = 1'b0;
            end
        endcase

        pulse_d = (state_d == HOLD);
        busy_d  = (state_d != IDLE);
    end

    // FSM, down-counter and output registers; reset wins over any trigger.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            pending_q <= 1'b0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
        end
    end

    assign o_pulse   = pulse_q;
    assign o_busy    = busy_q;
    assign o_pending = pending_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch: two instances (gap and no-gap) driven by
// directed and random triggers, checked every cycle against a timeline model.
module tb_pulse_stretch;

    localparam int H_A = 4;
    localparam int G_A = 2;
    localparam int H_B = 4;
    localparam int G_B = 0;

`ifdef PULSE_STRETCH_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    // Model state expressed as absolute cycle numbers of the pulse/gap ends.
    typedef struct {
        int hold_end;
        int gap_end;
        bit active;
        bit pending;
    } model_t;

    typedef struct {
        int cyc;
        bit a_pulse;
        bit a_busy;
        bit a_pend;
        bit b_pulse;
        bit b_busy;
        bit b_pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic trig = 1'b0;
    logic a_pulse, a_busy, a_pend;
    logic b_pulse, b_busy, b_pend;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t   sb_q[$];
    model_t ma;
    model_t mb;

    always #5 clk = ~clk;

    pulse_stretch #(.HOLD_CYCLES(H_A), .GAP_CYCLES(G_A)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_trigger(trig),
        .o_pulse(a_pulse), .o_busy(a_busy), .o_pending(a_pend)
    );

    pulse_stretch #(.HOLD_CYCLES(H_B), .GAP_CYCLES(G_B)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_trigger(trig),
        .o_pulse(b_pulse), .o_busy(b_busy), .o_pending(b_pend)
    );

    function automatic void chk(string name, int c, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %b expected %b", name, c, act, exp);
        end
    endfunction

    // Advance the model by one cycle t given the inputs sampled at t.
    function automatic model_t step(model_t m, int t, bit r, bit tg, int h, int g);
        model_t n = m;
        if (r) begin
            n.active  = 1'b0;
            n.pending = 1'b0;
        end else if (!m.active) begin
            if (tg) begin
                n.active   = 1'b1;
                n.hold_end = t + h;
                n.gap_end  = t + h + g;
            end
        end else if (t <= m.hold_end) begin
            if (tg) begin
                if (RETRIG) begin
                    n.hold_end = t + h;
                    n.gap_end  = t + h + g;
                end else begin
                    n.pending = 1'b1;
                end
            end
            if (g == 0 && t == n.hold_end) begin
                if (n.pending) begin
                    n.pending  = 1'b0;
                    n.hold_end = t + h;
                    n.gap_end  = t + h;
                end else begin
                    n.active = 1'b0;
                end
            end
        end else begin
            if (tg) n.pending = 1'b1;
            if (t == m.gap_end) begin
                if (n.pending) begin
                    n.pending  = 1'b0;
                    n.hold_end = t + h;
                    n.gap_end  = t + h + g;
                end else begin
                    n.active = 1'b0;
                end
            end
        end
        return n;
    endfunction

    task automatic drive(input bit r, input bit tg);
        exp_t e;
        @(negedge clk);
        rst  = r;
        trig = tg;
        ma = step(ma, cyc, r, tg, H_A, G_A);
        mb = step(mb, cyc, r, tg, H_B, G_B);
        e.cyc     = cyc + 1;
        e.a_pulse = ma.active && (cyc + 1 <= ma.hold_end);
        e.a_busy  = ma.active;
        e.a_pend  = ma.pending;
        e.b_pulse = mb.active && (cyc + 1 <= mb.hold_end);
        e.b_busy  = mb.active;
        e.b_pend  = mb.pending;
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("a_pulse",   e.cyc, a_pulse, e.a_pulse);
                chk("a_busy",    e.cyc, a_busy,  e.a_busy);
                chk("a_pending", e.cyc, a_pend,  e.a_pend);
                chk("b_pulse",   e.cyc, b_pulse, e.b_pulse);
                chk("b_busy",    e.cyc, b_busy,  e.b_busy);
                chk("b_pending", e.cyc, b_pend,  e.b_pend);
            end
        end
    end

    initial begin
        int density;
        ma = '{hold_end: -100, gap_end: -100, active: 1'b0, pending: 1'b0};
        mb = '{hold_end: -100, gap_end: -100, active: 1'b0, pending: 1'b0};

        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        idle(3);

        // Single trigger.
        drive(1'b0, 1'b1);
        idle(10);

        // Triggers at c0 and c2.
        drive(1'b0, 1'b1);
        idle(1);
        drive(1'b0, 1'b1);
        idle(14);

        // Trigger held high.
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1);
        idle(10);

        // Reset with simultaneous trigger mid-HOLD, then a fresh trigger.
        drive(1'b0, 1'b1);
        idle(1);
        drive(1'b1, 1'b1);
        idle(2);
        drive(1'b0, 1'b1);
        idle(10);

        // Triggers at c0 and c3.
        drive(1'b0, 1'b1);
        idle(2);
        drive(1'b0, 1'b1);
        idle(12);

        // Random bursts with varying trigger density and rare resets.
        for (int blk = 0; blk < 40; blk++) begin
            density = $urandom_range(0, 9);
            for (int i = 0; i < 50; i++) begin
                drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 9) < density) ? 1'b1 : 1'b0);
            end
        end
        idle(2);

        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
